// File: rtl/decode_execute_buffer_pkg.sv
// Shared encodings for the decode/execute pipeline buffer: ALU operations,
// push/pop codes and control-bus widths used by the control unit and buffers.
package decode_execute_buffer_pkg;

  localparam int CTRL_W = 10;
  localparam int ALU_W  = 4;
  localparam int PP_W   = 2;

  localparam logic [ALU_W-1:0] ALU_NOP = 4'h0;
  localparam logic [ALU_W-1:0] ALU_MOV = 4'h1;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'h2;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'h3;
  localparam logic [ALU_W-1:0] ALU_AND = 4'h4;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'h5;
  localparam logic [ALU_W-1:0] ALU_NOT = 4'h6;
  localparam logic [ALU_W-1:0] ALU_SHL = 4'h7;
  localparam logic [ALU_W-1:0] ALU_SHR = 4'h8;
  localparam logic [ALU_W-1:0] ALU_INC = 4'h9;
  localparam logic [ALU_W-1:0] ALU_DEC = 4'hA;

  localparam logic [PP_W-1:0] PP_NONE = 2'b00;
  localparam logic [PP_W-1:0] PP_PUSH = 2'b01;
  localparam logic [PP_W-1:0] PP_POP  = 2'b11;

  // A control-unit bubble carries no control, no ALU work and no stack traffic.
  function automatic logic isCuBubble(input logic [CTRL_W-1:0] ctrl,
                                      input logic [ALU_W-1:0]  alu,
                                      input logic [PP_W-1:0]   pp);
    return (ctrl == '0) && (alu == ALU_NOP) && (pp == PP_NONE);
  endfunction

endpackage

// File: rtl/decode_execute_buffer_pipe_reg.sv
// Generic pipeline register with synchronous active-low reset, flush-to-value
// and stall-hold; shared by the D2E, E2M and M2W buffers.
module pipe_reg #(
  parameter int            W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_stall,
  input  logic [W-1:0] i_d,
  input  logic [W-1:0] i_flushVal,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Priority: reset, then flush (wins over stall), then stall-hold, then load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= RST_VAL;
    end else if (i_flush) begin
      r_q <= i_flushVal;
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/decode_execute_buffer.sv
// Decode-to-execute pipeline buffer: registers CU control, operands and PC, and
// holds the CU's LDM/CALL/RET/flush sequencing state that feeds back next cycle.
module decode_execute_buffer
  import decode_execute_buffer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [9:0]        ctrlIn,
  input  logic [3:0]        aluSignalsIn,
  input  logic              shiftIn,
  input  logic [1:0]        pushPopIn,
  input  logic              stIn,
  input  logic              sstIn,
  input  logic [1:0]        flushNumIn,
  input  logic [1:0]        firstTimeCallIn,
  input  logic [1:0]        firstTimeRETIn,
  input  logic [DATA_W-1:0] rsrcDataIn,
  input  logic [DATA_W-1:0] rdstDataIn,
  input  logic [REG_AW-1:0] rsrcIdxIn,
  input  logic [REG_AW-1:0] rdstIdxIn,
  input  logic [DATA_W-1:0] immIn,
  input  logic [PC_W-1:0]   pcIn,
  input  logic              validIn,
  output logic [9:0]        ctrlOut,
  output logic [3:0]        aluSignalsOut,
  output logic              shiftOut,
  output logic [1:0]        pushPopOut,
  output logic              stOut,
  output logic              sstOut,
  output logic [1:0]        flushNumOut,
  output logic [1:0]        firstTimeCallOut,
  output logic [1:0]        firstTimeRETOut,
  output logic [DATA_W-1:0] rsrcDataOut,
  output logic [DATA_W-1:0] rdstDataOut,
  output logic [REG_AW-1:0] rsrcIdxOut,
  output logic [REG_AW-1:0] rdstIdxOut,
  output logic [DATA_W-1:0] immOut,
  output logic [PC_W-1:0]   pcOut,
  output logic              validOut
);

  localparam int CTRL_GRP_W = 1 + CTRL_W + ALU_W + 1 + PP_W;
  localparam int SEQ_GRP_W  = 8;
  localparam int OPS_GRP_W  = 3 * DATA_W + 2 * REG_AW;

  localparam logic [CTRL_GRP_W-1:0] CTRL_BUBBLE =
    {1'b0, {CTRL_W{1'b0}}, ALU_NOP, 1'b0, PP_NONE};

  logic                  w_validLoad;
  logic [CTRL_GRP_W-1:0] w_ctrlD, w_ctrlQ;
  logic [SEQ_GRP_W-1:0]  w_seqD, w_seqQ, w_seqFlush;
  logic [OPS_GRP_W-1:0]  w_opsD, w_opsQ;

  // CU-generated bubbles (e.g. the LDM first cycle) never reach execute as valid.
  assign w_validLoad = validIn & ~isCuBubble(ctrlIn, aluSignalsIn, pushPopIn);

  assign w_ctrlD = {w_validLoad, ctrlIn, aluSignalsIn, shiftIn, pushPopIn};

  pipe_reg #(.W(CTRL_GRP_W), .RST_VAL(CTRL_BUBBLE)) u_ctrlReg (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_stall    (stall),
    .i_d        (w_ctrlD),
    .i_flushVal (CTRL_BUBBLE),
    .o_q        (w_ctrlQ)
  );

  assign {validOut, ctrlOut, aluSignalsOut, shiftOut, pushPopOut} = w_ctrlQ;

  // A flush squashes LDM/CALL/RET sequencing but lets a flush countdown continue.
  assign w_seqD     = {stIn, sstIn, flushNumIn, firstTimeCallIn, firstTimeRETIn};
  assign w_seqFlush = {2'b00, flushNumIn, 2'b00, 2'b00};

  pipe_reg #(.W(SEQ_GRP_W), .RST_VAL('0)) u_seqReg (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_stall    (stall),
    .i_d        (w_seqD),
    .i_flushVal (w_seqFlush),
    .o_q        (w_seqQ)
  );

  assign {stOut, sstOut, flushNumOut, firstTimeCallOut, firstTimeRETOut} = w_seqQ;

  assign w_opsD = {rsrcDataIn, rdstDataIn, rsrcIdxIn, rdstIdxIn, immIn};

  pipe_reg #(.W(OPS_GRP_W), .RST_VAL('0)) u_opsReg (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_stall    (stall),
    .i_d        (w_opsD),
    .i_flushVal ({OPS_GRP_W{1'b0}}),
    .o_q        (w_opsQ)
  );

  assign {rsrcDataOut, rdstDataOut, rsrcIdxOut, rdstIdxOut, immOut} = w_opsQ;

  pipe_reg #(.W(PC_W), .RST_VAL('0)) u_pcReg (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_stall    (stall),
    .i_d        (pcIn),
    .i_flushVal ({PC_W{1'b0}}),
    .o_q        (pcOut)
  );

endmodule

// File: tb/tb_decode_execute_buffer.sv
// Testbench for decode_execute_buffer: directed pipeline scenarios followed by
// random traffic, all checked against a cycle-level behavioural model.
module tb_decode_execute_buffer;
  import decode_execute_buffer_pkg::*;

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [3:0]  alu;
    logic        shift;
    logic [1:0]  pp;
    logic        st;
    logic        sst;
    logic [1:0]  fn;
    logic [1:0]  ftc;
    logic [1:0]  ftr;
    logic [15:0] rs;
    logic [15:0] rd;
    logic [2:0]  rsi;
    logic [2:0]  rdi;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        valid;
  } fields_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush;
  logic [9:0]  ctrlIn;
  logic [3:0]  aluSignalsIn;
  logic        shiftIn;
  logic [1:0]  pushPopIn;
  logic        stIn, sstIn;
  logic [1:0]  flushNumIn, firstTimeCallIn, firstTimeRETIn;
  logic [15:0] rsrcDataIn, rdstDataIn, immIn;
  logic [2:0]  rsrcIdxIn, rdstIdxIn;
  logic [31:0] pcIn;
  logic        validIn;

  logic [9:0]  ctrlOut;
  logic [3:0]  aluSignalsOut;
  logic        shiftOut;
  logic [1:0]  pushPopOut;
  logic        stOut, sstOut;
  logic [1:0]  flushNumOut, firstTimeCallOut, firstTimeRETOut;
  logic [15:0] rsrcDataOut, rdstDataOut, immOut;
  logic [2:0]  rsrcIdxOut, rdstIdxOut;
  logic [31:0] pcOut;
  logic        validOut;

  decode_execute_buffer dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ctrlIn(ctrlIn), .aluSignalsIn(aluSignalsIn), .shiftIn(shiftIn),
    .pushPopIn(pushPopIn), .stIn(stIn), .sstIn(sstIn), .flushNumIn(flushNumIn),
    .firstTimeCallIn(firstTimeCallIn), .firstTimeRETIn(firstTimeRETIn),
    .rsrcDataIn(rsrcDataIn), .rdstDataIn(rdstDataIn), .rsrcIdxIn(rsrcIdxIn),
    .rdstIdxIn(rdstIdxIn), .immIn(immIn), .pcIn(pcIn), .validIn(validIn),
    .ctrlOut(ctrlOut), .aluSignalsOut(aluSignalsOut), .shiftOut(shiftOut),
    .pushPopOut(pushPopOut), .stOut(stOut), .sstOut(sstOut),
    .flushNumOut(flushNumOut), .firstTimeCallOut(firstTimeCallOut),
    .firstTimeRETOut(firstTimeRETOut), .rsrcDataOut(rsrcDataOut),
    .rdstDataOut(rdstDataOut), .rsrcIdxOut(rsrcIdxOut), .rdstIdxOut(rdstIdxOut),
    .immOut(immOut), .pcOut(pcOut), .validOut(validOut)
  );

  fields_t cur, exp;
  logic    curRst, curStall, curFlush;
  int      testsRun = 0;
  int      testsFailed = 0;

  function automatic fields_t bubbleFields();
    fields_t f;
    f = '0;
    f.alu = ALU_NOP;
    return f;
  endfunction

  function automatic fields_t randFields();
    fields_t f;
    f.ctrl  = 10'($urandom);
    f.alu   = 4'($urandom);
    f.shift = 1'($urandom);
    f.pp    = 2'($urandom);
    f.st    = 1'($urandom);
    f.sst   = 1'($urandom);
    f.fn    = 2'($urandom);
    f.ftc   = 2'($urandom);
    f.ftr   = 2'($urandom);
    f.rs    = 16'($urandom);
    f.rd    = 16'($urandom);
    f.rsi   = 3'($urandom);
    f.rdi   = 3'($urandom);
    f.imm   = 16'($urandom);
    f.pc    = $urandom;
    f.valid = 1'($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 3) == 0) begin
      f.ctrl = '0;
      f.alu  = ALU_NOP;
      f.pp   = 2'b00;
    end
    return f;
  endfunction

  task automatic applyStimulus(input logic r, input logic s, input logic fl,
                               input fields_t f);
    curRst = r; curStall = s; curFlush = fl; cur = f;
    rst = r; stall = s; flush = fl;
    ctrlIn = f.ctrl; aluSignalsIn = f.alu; shiftIn = f.shift; pushPopIn = f.pp;
    stIn = f.st; sstIn = f.sst; flushNumIn = f.fn;
    firstTimeCallIn = f.ftc; firstTimeRETIn = f.ftr;
    rsrcDataIn = f.rs; rdstDataIn = f.rd; rsrcIdxIn = f.rsi; rdstIdxIn = f.rdi;
    immIn = f.imm; pcIn = f.pc; validIn = f.valid;
  endtask

  task automatic checkField(input string tag, input logic [31:0] obs,
                            input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string ctx);
    checkField({ctx, ".ctrl"},  32'(ctrlOut),          32'(exp.ctrl));
    checkField({ctx, ".alu"},   32'(aluSignalsOut),    32'(exp.alu));
    checkField({ctx, ".shift"}, 32'(shiftOut),         32'(exp.shift));
    checkField({ctx, ".pp"},    32'(pushPopOut),       32'(exp.pp));
    checkField({ctx, ".st"},    32'(stOut),            32'(exp.st));
    checkField({ctx, ".sst"},   32'(sstOut),           32'(exp.sst));
    checkField({ctx, ".fn"},    32'(flushNumOut),      32'(exp.fn));
    checkField({ctx, ".ftc"},   32'(firstTimeCallOut), 32'(exp.ftc));
    checkField({ctx, ".ftr"},   32'(firstTimeRETOut),  32'(exp.ftr));
    checkField({ctx, ".rs"},    32'(rsrcDataOut),      32'(exp.rs));
    checkField({ctx, ".rd"},    32'(rdstDataOut),      32'(exp.rd));
    checkField({ctx, ".rsi"},   32'(rsrcIdxOut),       32'(exp.rsi));
    checkField({ctx, ".rdi"},   32'(rdstIdxOut),       32'(exp.rdi));
    checkField({ctx, ".imm"},   32'(immOut),           32'(exp.imm));
    checkField({ctx, ".pc"},    32'(pcOut),            32'(exp.pc));
    checkField({ctx, ".valid"}, 32'(validOut),         32'(exp.valid));
  endtask

  // One clock edge: update the reference model from the applied inputs, then
  // sample the DUT shortly after the edge.
  task automatic step(input string ctx);
    @(posedge clk);
    if (!curRst) begin
      exp = bubbleFields();
    end else if (curFlush) begin
      exp = bubbleFields();
      exp.fn = cur.fn;
    end else if (!curStall) begin
      exp = cur;
      if (cur.ctrl == 10'd0 && cur.alu == ALU_NOP && cur.pp == 2'b00)
        exp.valid = 1'b0;
    end
    #1;
    checkOutput(ctx);
  endtask

  initial begin
    fields_t f;
    fields_t nz;

    // Reset with every input driven nonzero.
    nz = '1;
    nz.alu = ALU_ADD;
    applyStimulus(1'b0, 1'b1, 1'b1, nz);
    step("reset1");
    step("reset2");
    checkField("reset.valid", 32'(validOut), 32'd0);
    checkField("reset.alu", 32'(aluSignalsOut), 32'(ALU_NOP));

    // LDM: first cycle is a CU bubble carrying st=sst=1.
    f = bubbleFields();
    f.st = 1'b1; f.sst = 1'b1; f.valid = 1'b1; f.pc = 32'h0000_0004;
    applyStimulus(1'b1, 1'b0, 1'b0, f);
    step("ldm1");
    checkField("ldm1.st", 32'(stOut), 32'd1);
    checkField("ldm1.sst", 32'(sstOut), 32'd1);
    checkField("ldm1.valid", 32'(validOut), 32'd0);
    f = bubbleFields();
    f.ctrl = 10'b0000011000; f.alu = ALU_MOV; f.imm = 16'hBEEF;
    f.st = 1'b1; f.sst = 1'b0; f.valid = 1'b1; f.rdi = 3'd5;
    applyStimulus(1'b1, 1'b0, 1'b0, f);
    step("ldm2");
    checkField("ldm2.imm", 32'(immOut), 32'hBEEF);
    checkField("ldm2.rw", 32'(ctrlOut[3]), 32'd1);
    checkField("ldm2.alusrc", 32'(ctrlOut[4]), 32'd1);
    checkField("ldm2.valid", 32'(validOut), 32'd1);
    checkField("ldm2.sst", 32'(sstOut), 32'd0);

    // Stall: ADD at pc 0x10 must hold for three stalled edges.
    f = randFields();
    f.ctrl = 10'b0000001000; f.alu = ALU_ADD; f.pp = 2'b00;
    f.pc = 32'h0000_0010; f.valid = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, f);
    step("add");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, randFields());
      step("stall");
      checkField("stall.pc", 32'(pcOut), 32'h10);
      checkField("stall.alu", 32'(aluSignalsOut), 32'(ALU_ADD));
    end
    f = randFields();
    f.pc = 32'h0000_0012;
    applyStimulus(1'b1, 1'b0, 1'b0, f);
    step("resume");
    checkField("resume.pc", 32'(pcOut), 32'h12);

    // Flush together with stall: bubble, countdown kept, CALL code cleared.
    f = randFields();
    f.fn = 2'd2; f.ftc = 2'b11;
    applyStimulus(1'b1, 1'b1, 1'b1, f);
    step("flushstall");
    checkField("flushstall.fn", 32'(flushNumOut), 32'd2);
    checkField("flushstall.ftc", 32'(firstTimeCallOut), 32'd0);
    checkField("flushstall.valid", 32'(validOut), 32'd0);

    // RET countdown driven through CU bubbles.
    for (int n = 2; n >= 0; n--) begin
      f = bubbleFields();
      f.fn = 2'(n); f.valid = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, f);
      step("retcount");
      checkField("retcount.fn", 32'(flushNumOut), 32'(n));
      checkField("retcount.valid", 32'(validOut), 32'd0);
    end

    // Reset in the middle of a CALL sequence.
    f = randFields();
    f.ctrl = 10'b0001000000; f.pp = PP_PUSH; f.ftc = 2'b11; f.valid = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, f);
    step("call1");
    checkField("call1.ftc", 32'(firstTimeCallOut), 32'b11);
    applyStimulus(1'b0, 1'b0, 1'b0, randFields());
    step("callrst");
    checkField("callrst.ftc", 32'(firstTimeCallOut), 32'd0);
    checkField("callrst.pp", 32'(pushPopOut), 32'd0);

    // Random traffic with occasional reset, flush and stall.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 7) == 0), randFields());
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
